ast_packer: RTL and testbench

- Downstream consumer of the byte FIFO.
- Pops DATAWIDTH-wide entries one at a time and packs LANES consecutive entries into one wide word.
- Presents the packed word on a valid/ready output interface towards the accelerator datapath.
- Supports a flush that emits a partial word zero-padded, plus a count of valid lanes.

---
 rtl/ast_pkg.sv | 13 +
 rtl/ast_lane_ctr.sv | 30 +++
 rtl/ast_packer.sv | 98 +++++++++
 tb/tb_ast_packer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ast_pkg.sv
// Shared types and helpers for the FIFO-to-wide-word packer.
package ast_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pk_state_t;

    function automatic int calc_cw(input int lanes);
        return $clog2(lanes + 1);
    endfunction

endpackage

// File: rtl/ast_lane_ctr.sv
// Issued/captured lane counters with the in-flight compare.
module ast_lane_ctr #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          issue,
    input  logic          capture,
    output logic [CW-1:0] issued,
    output logic [CW-1:0] captured,
    output logic          settled
);

    // Equal counts mean no pop is waiting for its data.
    assign settled = (issued == captured);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            issued   <= '0;
            captured <= '0;
        end else begin
            if (issue)
                issued <= issued + CW'(1);
            if (capture)
                captured <= captured + CW'(1);
        end
    end

endmodule

// File: rtl/ast_packer.sv
// Pops FIFO entries and packs LANES of them into one wide output word.
module ast_packer
    import ast_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int LANES     = 4,
    localparam int CW       = calc_cw(LANES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fifo_empty,
    output logic                       fifo_pop,
    input  logic [DATAWIDTH-1:0]       fifo_data,
    input  logic                       flush,
    output logic [DATAWIDTH*LANES-1:0] out_data,
    output logic [CW-1:0]              out_count,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int IW = $clog2(LANES);
    localparam logic [CW-1:0] LANES_C = CW'(LANES);
    localparam logic [CW-1:0] LAST    = CW'(LANES - 1);

    pk_state_t state;
    logic      flush_pend;
    logic      pop_d;
    logic      handshake;
    logic      settled;
    logic [CW-1:0] issued;
    logic [CW-1:0] captured;
    logic [LANES-1:0][DATAWIDTH-1:0] lanes;

    assign handshake = out_valid && out_ready;
    assign out_data  = lanes;

    assign fifo_pop = (state == FILL) && !fifo_empty
                   && (issued < LANES_C) && !flush_pend;

    ast_lane_ctr #(
        .CW(CW)
    ) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .clr      (handshake),
        .issue    (fifo_pop),
        .capture  (pop_d),
        .issued   (issued),
        .captured (captured),
        .settled  (settled)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            flush_pend <= 1'b0;
            pop_d      <= 1'b0;
            out_valid  <= 1'b0;
            out_count  <= '0;
            lanes      <= '0;
        end else begin
            pop_d <= fifo_pop;
            unique case (state)
                FILL: begin
                    if (pop_d) begin
                        lanes[captured[IW-1:0]] <= fifo_data;
                        if (captured == LAST) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            out_count <= LANES_C;
                        end
                    end else if (flush_pend && settled) begin
                        // Nothing captured means the flush has nothing to emit.
                        if (captured != '0) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            out_count <= captured;
                        end else begin
                            flush_pend <= 1'b0;
                        end
                    end
                    if (flush)
                        flush_pend <= 1'b1;
                end
                HOLD: begin
                    if (out_ready) begin
                        state      <= FILL;
                        out_valid  <= 1'b0;
                        flush_pend <= 1'b0;
                        lanes      <= '0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_ast_packer.sv
// Directed bench for ast_packer with a small FIFO model.
module tb_ast_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty = 1'b1;
    logic        fifo_pop;
    logic [7:0]  fifo_data = '0;
    logic        flush = 1'b0;
    logic [31:0] out_data;
    logic [2:0]  out_count;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    int pop_cnt = 0;
    int pop_empty_err = 0;
    logic [7:0] q[$];

    ast_packer #(.DATAWIDTH(8), .LANES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .fifo_data  (fifo_data),
        .flush      (flush),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    // FIFO model: registered empty flag, data valid the cycle after a pop.
    always @(posedge clk) begin
        if (fifo_pop && fifo_empty)
            pop_empty_err++;
        if (fifo_pop && q.size() > 0) begin
            fifo_data <= q.pop_front();
            pop_cnt++;
        end
        fifo_empty <= (q.size() == 0);
    end

    typedef struct {
        int          n;
        logic [7:0]  b [4];
        bit          fl;
        logic [31:0] d;
        int          c;
    } vec_t;

    vec_t tv [6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic get_word(output logic [31:0] d, output int c,
                            input string nm);
        bit ok = 0;
        d = '0;
        c = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                d  = out_data;
                c  = int'(out_count);
                ok = 1;
                break;
            end
        end
        chk({nm, "_timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_pops(input int target, input string nm);
        bit ok = 0;
        for (int i = 0; i < 60; i++) begin
            if (pop_cnt >= target) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk({nm, "_pop_timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    initial begin
        logic [31:0] d, d0;
        int c, t0, t1, npop, base;
        bit bad;

        tv[0] = '{4, '{8'h11, 8'h22, 8'h33, 8'h44}, 1'b0, 32'h44332211, 4};
        tv[1] = '{4, '{8'h55, 8'h66, 8'h77, 8'h88}, 1'b0, 32'h88776655, 4};
        tv[2] = '{2, '{8'hAA, 8'hBB, 8'h00, 8'h00}, 1'b1, 32'h0000BBAA, 2};
        tv[3] = '{1, '{8'h5A, 8'h00, 8'h00, 8'h00}, 1'b1, 32'h0000005A, 1};
        tv[4] = '{3, '{8'h01, 8'h02, 8'h03, 8'h00}, 1'b1, 32'h00030201, 3};
        tv[5] = '{4, '{8'hFF, 8'h00, 8'hFF, 8'h80}, 1'b0, 32'h80FF00FF, 4};

        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_pop", 32'(fifo_pop), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Continuous fill: pop cadence and first-pop-to-valid latency.
        q.push_back(8'h11); q.push_back(8'h22);
        q.push_back(8'h33); q.push_back(8'h44);
        t0 = -1; t1 = -1; npop = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fifo_pop) begin
                if (t0 < 0) t0 = i;
                npop++;
            end
            if (out_valid) begin
                t1 = i;
                d  = out_data;
                c  = int'(out_count);
                break;
            end
        end
        chk("lat_first_pop_seen", 32'(t0 >= 0), 32'd1);
        chk("lat_cycles", 32'(t1 - t0), 32'd5);
        chk("lat_pops", 32'(npop), 32'd4);
        chk("lat_data", d, 32'h44332211);
        chk("lat_count", 32'(c), 32'd4);

        for (int k = 0; k < 6; k++) begin
            base = pop_cnt;
            for (int j = 0; j < tv[k].n; j++)
                q.push_back(tv[k].b[j]);
            if (tv[k].fl) begin
                wait_pops(base + tv[k].n, $sformatf("vec%0d", k));
                pulse_flush();
            end
            get_word(d, c, $sformatf("vec%0d", k));
            chk($sformatf("vec%0d_data", k), d, tv[k].d);
            chk($sformatf("vec%0d_count", k), 32'(c), 32'(tv[k].c));
        end

        // Backpressure: word held stable, no pops while held.
        @(negedge clk);
        out_ready = 1'b0;
        for (int j = 1; j <= 8; j++)
            q.push_back(8'(j * 8'h11));
        get_word(d0, c, "bp_w1");
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!out_valid || out_data !== d0 || fifo_pop)
                bad = 1;
        end
        chk("bp_stable", 32'(bad), 32'd0);
        chk("bp_w1_data", d0, 32'h44332211);
        chk("bp_w1_count", 32'(out_count), 32'd4);
        out_ready = 1'b1;
        get_word(d, c, "bp_w2");
        chk("bp_w2_data", d, 32'h88776655);
        chk("bp_w2_count", 32'(c), 32'd4);

        // Empty flush is dropped; next word packs normally.
        repeat (3) @(negedge clk);
        pulse_flush();
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) bad = 1;
            @(negedge clk);
        end
        chk("eflush_no_word", 32'(bad), 32'd0);
        q.push_back(8'h21); q.push_back(8'h43);
        q.push_back(8'h65); q.push_back(8'h87);
        get_word(d, c, "eflush_next");
        chk("eflush_next_data", d, 32'h87654321);
        chk("eflush_next_count", 32'(c), 32'd4);

        // Stall mid-fill: partial lanes retained across a long gap.
        @(negedge clk);
        q.push_back(8'hAA); q.push_back(8'hBB);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) bad = 1;
        end
        chk("stall_no_word", 32'(bad), 32'd0);
        q.push_back(8'hCC); q.push_back(8'hDD);
        get_word(d, c, "stall");
        chk("stall_data", d, 32'hDDCCBBAA);
        chk("stall_count", 32'(c), 32'd4);

        // Reset after two captures discards the partial word.
        @(negedge clk);
        base = pop_cnt;
        q.push_back(8'h12); q.push_back(8'h34);
        wait_pops(base + 2, "rmid");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rmid_valid", 32'(out_valid), 32'd0);
        chk("rmid_count", 32'(out_count), 32'd0);
        chk("rmid_data", out_data, 32'd0);
        chk("rmid_pop", 32'(fifo_pop), 32'd0);
        rst = 1'b0;
        q.push_back(8'h9A); q.push_back(8'hBC);
        q.push_back(8'hDE); q.push_back(8'hF0);
        get_word(d, c, "rmid_next");
        chk("rmid_next_data", d, 32'hF0DEBC9A);
        chk("rmid_next_count", 32'(c), 32'd4);

        repeat (3) @(negedge clk);
        chk("no_pop_when_empty", 32'(pop_empty_err), 32'd0);
        chk("fifo_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
